// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM (M) and MEM/WB (W) registers around a
// combinational-read data RAM, with sticky fault capture and load/store counters.
module mem_stage #(
    parameter int DEPTH = 10,
    parameter int AW    = 6,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          ex_mem_rd,
    input  logic          ex_mem_wr,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_wdata,
    input  logic [DW-1:0] ex_alu,
    input  logic [2:0]    ex_rd,
    input  logic          ex_regwrite,
    input  logic          stall,
    input  logic          flush,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do,
    output logic          wb_valid,
    output logic          wb_regwrite,
    output logic [2:0]    wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          fault,
    output logic [AW-1:0] fault_addr,
    output logic [7:0]    ld_cnt,
    output logic [7:0]    st_cnt
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic          m_valid;
    logic          m_rd;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_alu;
    logic [2:0]    m_rdi;
    logic          m_regwrite;

    logic in_range;
    logic bad_access;
    logic legal_ld;
    logic legal_st;

    // Only memory instructions can fault; a plain ALU op with a wild addr is fine.
    assign in_range   = {1'b0, m_addr} < DEPTH_W;
    assign bad_access = m_valid & (m_rd | m_wr) & (~in_range | (m_rd & m_wr));
    assign legal_ld   = m_valid & m_rd & ~m_wr & in_range;
    assign legal_st   = m_valid & m_wr & ~m_rd & in_range;

    assign ram_a  = m_addr;
    assign ram_di = m_wdata;
    assign ram_we = legal_st & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_rd       <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_alu      <= '0;
            m_rdi      <= '0;
            m_regwrite <= 1'b0;
        end else if (!stall) begin
            m_valid    <= ex_valid & ~flush;
            m_rd       <= ex_mem_rd;
            m_wr       <= ex_mem_wr;
            m_addr     <= ex_addr;
            m_wdata    <= ex_wdata;
            m_alu      <= ex_alu;
            m_rdi      <= ex_rd;
            m_regwrite <= ex_regwrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            fault       <= 1'b0;
            fault_addr  <= '0;
            ld_cnt      <= '0;
            st_cnt      <= '0;
        end else if (!stall) begin
            wb_valid    <= m_valid;
            wb_rd       <= m_rdi;
            wb_regwrite <= m_regwrite & m_valid & ~m_wr & ~bad_access;
            if (legal_ld)
                wb_data <= ram_do;
            else if (m_valid && m_rd && bad_access)
                wb_data <= '0;
            else
                wb_data <= m_alu;
            if (bad_access) begin
                fault <= 1'b1;
                if (!fault)
                    fault_addr <= m_addr;
            end
            if (legal_ld && ld_cnt != 8'hFF)
                ld_cnt <= ld_cnt + 8'd1;
            if (legal_st && st_cnt != 8'hFF)
                st_cnt <= st_cnt + 8'd1;
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 10, number of valid data-RAM words (legal addresses 0..DEPTH-1).
REQ-002 SHALL have parameter AW, default 6, RAM address width.
REQ-003 SHALL have parameter DW, default 16, data width.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ex_valid  in  1  EX/MEM slot carries a real instruction.
REQ-007 ex_mem_rd  in  1  instruction is a load.
REQ-008 ex_mem_wr  in  1  instruction is a store.
REQ-009 ex_addr  in  AW  effective word address.
REQ-010 ex_wdata  in  DW  store data.
REQ-011 ex_alu  in  DW  ALU result for non-memory instructions.
REQ-012 ex_rd  in  3  destination register index.
REQ-013 ex_regwrite  in  1  instruction writes the register file.
REQ-014 stall  in  1  hold both stage registers this cycle.
REQ-015 flush  in  1  kill the instruction entering the MEM stage.
REQ-016 ram_we  out  1  data-RAM write enable (RAM writes at posedge when high).
REQ-017 ram_a  out  AW  data-RAM address.
REQ-018 ram_di  out  DW  data-RAM write data.
REQ-019 ram_do  in  DW  data-RAM combinational read data.
REQ-020 wb_valid, wb_regwrite  out  1 each  MEM/WB slot valid and register-write qualifier.
REQ-021 wb_rd  out  3;  wb_data  out  DW  write-back destination and value.
REQ-022 fault  out  1;  fault_addr  out  AW  sticky access fault and first faulting address.
REQ-023 ld_cnt, st_cnt  out  8 each  saturating counts of completed loads and stores.

Function
REQ-024 SHALL hold an M register (valid, rd, wr, addr, wdata, alu, rd index, regwrite) loaded from ex_* at posedge when stall=0.
REQ-025 On posedge with stall=0 and flush=1, M.valid SHALL become 0 regardless of ex_valid.
REQ-026 ram_a SHALL equal M.addr and ram_di SHALL equal M.wdata combinationally.
REQ-027 ram_we SHALL be 1 only when M.valid=1, M.wr=1, M.rd=0, M.addr<DEPTH and stall=0; so each store writes exactly once, at the edge M advances.
REQ-028 Memory access is legal when M.valid=1, M.addr<DEPTH and not (M.rd and M.wr); otherwise the access is a fault.
REQ-029 W register SHALL load from M at posedge when stall=0: wb_valid=M.valid, wb_rd=M.rd index.
REQ-030 wb_data SHALL be ram_do for a legal load, 16'h0000 for a faulting load, M.alu otherwise.
REQ-031 wb_regwrite SHALL be M.regwrite and M.valid, forced 0 for stores and faulting accesses.
REQ-032 Latency: instruction accepted at edge N drives RAM during cycle N..N+1, writes RAM at edge N+1, and appears on wb_* after edge N+1 (1 cycle).
REQ-033 While stall=1 M, W, counters and fault state SHALL hold and ram_we SHALL be 0.
REQ-034 On a faulting access advancing (stall=0): fault SHALL set and remain 1 until reset; fault_addr SHALL capture M.addr only if fault was 0.
REQ-035 ld_cnt/st_cnt SHALL increment on each legal load/store advancing, saturating at 255.
REQ-036 Simultaneous stall=1 and flush=1: stall wins; flush ignored that cycle.
REQ-037 Bubbles (M.valid=0) SHALL cause no RAM write, no fault, no count.

Reset
REQ-038 rst=1 SHALL immediately clear M and W to all zeros, giving ram_we=0, wb_valid=0, wb_regwrite=0, wb_rd=0, wb_data=0.
REQ-039 rst=1 SHALL clear fault, fault_addr, ld_cnt and st_cnt to 0; reset mid-store SHALL suppress that write.

Verification
REQ-040 Store addr 3 data 16'hBEEF, then load addr 3 -> ram_we pulses one cycle with ram_a=3; next cycle wb_data=16'hBEEF, wb_regwrite=1, ld_cnt=1, st_cnt=1.
REQ-041 Store addr 5 with stall=1 for 3 cycles -> ram_we=0 during stall, exactly one write when stall drops, st_cnt=1.
REQ-042 Load addr 12 then store addr 10 -> fault=1, fault_addr=12, wb_data=0, wb_regwrite=0, no RAM write, counters 0.
REQ-043 ALU instruction (alu=16'h1234, rd=2) with flush=1 at accept -> wb_valid=0 next cycle; without flush -> wb_data=16'h1234, wb_rd=2.
REQ-044 Assert rst while a store to addr 1 sits in M -> ram_we drops asynchronously, all outputs 0, RAM word 1 unchanged.
REQ-045 300 legal loads -> ld_cnt saturates at 255.
